palette_mapper: RTL and testbench

PALETTE_MAPPER -- requirements
Module: palette_mapper

---
 rtl/palette_mapper_if.sv | 45 ++++
 rtl/palette_mapper.sv | 124 ++++++++++++
 tb/tb_palette_mapper.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_mapper_if.sv
// Pixel lookup, palette write and colour output bundle for palette_mapper.
// Readback signals exist only when PALETTE_READBACK_EN is defined.
interface palette_mapper_if #(
    parameter int PAT_W = 2,
    parameter int IDX_W = 2,
    parameter int CW    = 8
);
    logic                   pix_valid;
    logic                   blank;
    logic                   vblank;
    logic [PAT_W-1:0]       pattern;
    logic [IDX_W-1:0]       color_idx;
    logic                   pal_wr_valid;
    logic                   pal_wr_ready;
    logic [PAT_W+IDX_W-1:0] pal_wr_addr;
    logic [3*CW-1:0]        pal_wr_data;
    logic                   out_valid;
    logic [CW-1:0]          VGA_R;
    logic [CW-1:0]          VGA_G;
    logic [CW-1:0]          VGA_B;
`ifdef PALETTE_READBACK_EN
    logic [PAT_W+IDX_W-1:0] rd_addr;
    logic [3*CW-1:0]        rd_data;
`endif

    modport master (
`ifdef PALETTE_READBACK_EN
        output rd_addr,
        input  rd_data,
`endif
        output pix_valid, blank, vblank, pattern, color_idx,
        output pal_wr_valid, pal_wr_addr, pal_wr_data,
        input  pal_wr_ready, out_valid, VGA_R, VGA_G, VGA_B
    );

    modport slave (
`ifdef PALETTE_READBACK_EN
        input  rd_addr,
        output rd_data,
`endif
        input  pix_valid, blank, vblank, pattern, color_idx,
        input  pal_wr_valid, pal_wr_addr, pal_wr_data,
        output pal_wr_ready, out_valid, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/palette_mapper.sv
// Two-stage palette lookup with vblank-deferred palette writes.
// Optional readback port enabled by defining PALETTE_READBACK_EN.
module palette_mapper #(
    parameter int PAT_W = 2,
    parameter int IDX_W = 2,
    parameter int CW    = 8
) (
    input logic              clk,
    input logic              rst,
    palette_mapper_if.slave  bus
);
    localparam int AW    = PAT_W + IDX_W;
    localparam int DEPTH = 1 << AW;
    localparam int DW    = 3 * CW;

    // Grey ramp: each channel is the colour index bit-replicated to CW bits.
    function automatic logic [DW-1:0] default_entry(input int unsigned a);
        logic [IDX_W-1:0] idx;
        logic [CW-1:0]    ch;
        idx = IDX_W'(a);
        ch  = '0;
        for (int b = 0; b < CW; b++) begin
            ch[CW-1-b] = idx[IDX_W-1-(b % IDX_W)];
        end
        return {ch, ch, ch};
    endfunction

    logic [DW-1:0] pal_q [DEPTH];

    logic          s1_valid_q, s1_valid_d;
    logic          s1_blank_q, s1_blank_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;

    logic          hold_valid_q, hold_valid_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_data_q, hold_data_d;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] rgb_q, rgb_d;

    logic          wr_fire;
    logic          commit;
    logic [DW-1:0] rd_word;

    assign wr_fire = bus.pal_wr_valid && !hold_valid_q;
    assign commit  = hold_valid_q && bus.vblank;

    // Write-first bypass when the committing entry is being looked up.
    assign rd_word = (commit && hold_addr_q == s1_addr_q)
                   ? hold_data_q : pal_q[s1_addr_q];

    always_comb begin
        s1_valid_d   = bus.pix_valid;
        s1_blank_d   = bus.blank;
        s1_addr_d    = {bus.pattern, bus.color_idx};
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        out_valid_d  = s1_valid_q;
        rgb_d        = rgb_q;
        if (commit) begin
            hold_valid_d = 1'b0;
        end else if (wr_fire) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = bus.pal_wr_addr;
            hold_data_d  = bus.pal_wr_data;
        end
        if (s1_valid_q) begin
            rgb_d = s1_blank_q ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_blank_q   <= 1'b0;
            s1_addr_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            out_valid_q  <= 1'b0;
            rgb_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_blank_q   <= s1_blank_d;
            s1_addr_q    <= s1_addr_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            out_valid_q  <= out_valid_d;
            rgb_q        <= rgb_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal_q[i] <= default_entry(i);
            end
        end else if (commit) begin
            pal_q[hold_addr_q] <= hold_data_q;
        end
    end

    assign bus.pal_wr_ready = !hold_valid_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.VGA_R        = rgb_q[3*CW-1:2*CW];
    assign bus.VGA_G        = rgb_q[2*CW-1:CW];
    assign bus.VGA_B        = rgb_q[CW-1:0];

`ifdef PALETTE_READBACK_EN
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= pal_q[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_palette_mapper.sv
// Directed self-checking bench for palette_mapper.
// Readback checks are compiled in when PALETTE_READBACK_EN is defined.
module tb_palette_mapper;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    palette_mapper_if #(.PAT_W(2), .IDX_W(2), .CW(8)) bus ();

    palette_mapper #(.PAT_W(2), .IDX_W(2), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [1:0] pat, input logic [1:0] idx,
                          input logic blk,
                          output logic [23:0] rgb, output logic ov);
        bus.pix_valid = 1'b1;
        bus.pattern   = pat;
        bus.color_idx = idx;
        bus.blank     = blk;
        tick();
        bus.pix_valid = 1'b0;
        bus.blank     = 1'b0;
        tick();
        rgb = {bus.VGA_R, bus.VGA_G, bus.VGA_B};
        ov  = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_rgb got %h want 000000",
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        checks++;
        if (bus.pal_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.pal_wr_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        logic [23:0] exp_rgb [4];
        exp_rgb[0] = 24'h000000;
        exp_rgb[1] = 24'h555555;
        exp_rgb[2] = 24'hAAAAAA;
        exp_rgb[3] = 24'hFFFFFF;
        for (int i = 0; i < 5; i++) begin
            bus.pix_valid = (i < 4);
            bus.pattern   = 2'd1;
            bus.color_idx = 2'(i);
            tick();
            if (i >= 1) begin
                checks++;
                if (bus.out_valid !== 1'b1 ||
                    {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== exp_rgb[i-1]) begin
                    errors++;
                    $display("FAIL sweep_idx%0d got %b/%h want 1/%h", i - 1,
                             bus.out_valid, {bus.VGA_R, bus.VGA_G, bus.VGA_B},
                             exp_rgb[i-1]);
                end
            end
        end
        bus.pix_valid = 1'b0;
        tick();
    endtask

    task automatic test_blank();
        bus.pix_valid = 1'b1;
        bus.pattern   = 2'd0;
        bus.color_idx = 2'd3;
        bus.blank     = 1'b1;
        tick();
        bus.blank     = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 ||
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h000000) begin
            errors++;
            $display("FAIL blank_black got %b/%h want 1/000000", bus.out_valid,
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        bus.pix_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 ||
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL blank_next got %b/%h want 1/ffffff", bus.out_valid,
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL idle_hold got %h want ffffff",
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
    endtask

    task automatic test_deferred_write();
        logic [23:0] rgb;
        logic        ov;
        bus.vblank       = 1'b0;
        bus.pal_wr_valid = 1'b1;
        bus.pal_wr_addr  = 4'd5;
        bus.pal_wr_data  = 24'h123456;
        tick();
        bus.pal_wr_valid = 1'b0;
        checks++;
        if (bus.pal_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL defer_ready_low got %b want 0", bus.pal_wr_ready);
        end
        lookup(2'd1, 2'd1, 1'b0, rgb, ov);
        checks++;
        if (ov !== 1'b1 || rgb !== 24'h555555) begin
            errors++;
            $display("FAIL defer_old got %b/%h want 1/555555", ov, rgb);
        end
        bus.vblank = 1'b1;
        checks++;
        if (bus.pal_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_cycle_ready got %b want 0", bus.pal_wr_ready);
        end
        tick();
        bus.vblank = 1'b0;
        checks++;
        if (bus.pal_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL defer_ready_high got %b want 1", bus.pal_wr_ready);
        end
        lookup(2'd1, 2'd1, 1'b0, rgb, ov);
        checks++;
        if (ov !== 1'b1 || rgb !== 24'h123456) begin
            errors++;
            $display("FAIL defer_new got %b/%h want 1/123456", ov, rgb);
        end
    endtask

    task automatic test_collision();
        logic [23:0] rgb;
        logic        ov;
        bus.vblank       = 1'b1;
        bus.pal_wr_valid = 1'b1;
        bus.pal_wr_addr  = 4'd2;
        bus.pal_wr_data  = 24'hABCDEF;
        bus.pix_valid    = 1'b1;
        bus.pattern      = 2'd0;
        bus.color_idx    = 2'd2;
        tick();
        bus.pal_wr_valid = 1'b0;
        bus.pix_valid    = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 ||
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'hABCDEF) begin
            errors++;
            $display("FAIL collision got %b/%h want 1/abcdef", bus.out_valid,
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        bus.vblank = 1'b0;
        lookup(2'd0, 2'd2, 1'b0, rgb, ov);
        checks++;
        if (rgb !== 24'hABCDEF) begin
            errors++;
            $display("FAIL collision_stored got %h want abcdef", rgb);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] rgb;
        logic        ov;
        bus.vblank       = 1'b0;
        bus.pal_wr_valid = 1'b1;
        bus.pal_wr_addr  = 4'd9;
        bus.pal_wr_data  = 24'h111111;
        tick();
        bus.pal_wr_addr  = 4'd10;
        bus.pal_wr_data  = 24'h222222;
        tick();
        tick();
        checks++;
        if (bus.pal_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready got %b want 0", bus.pal_wr_ready);
        end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        tick();
        bus.pal_wr_valid = 1'b0;
        checks++;
        if (bus.pal_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_held got %b want 0", bus.pal_wr_ready);
        end
        lookup(2'd2, 2'd1, 1'b0, rgb, ov);
        checks++;
        if (rgb !== 24'h111111) begin
            errors++;
            $display("FAIL bp_first got %h want 111111", rgb);
        end
        lookup(2'd2, 2'd2, 1'b0, rgb, ov);
        checks++;
        if (rgb !== 24'hAAAAAA) begin
            errors++;
            $display("FAIL bp_second_pending got %h want aaaaaa", rgb);
        end
        bus.vblank = 1'b1;
        tick();
        tick();
        bus.vblank = 1'b0;
        lookup(2'd2, 2'd2, 1'b0, rgb, ov);
        checks++;
        if (rgb !== 24'h222222) begin
            errors++;
            $display("FAIL bp_second got %h want 222222", rgb);
        end
    endtask

    task automatic test_reset_midflight();
        logic [23:0] rgb;
        logic        ov;
        bus.vblank       = 1'b0;
        bus.pal_wr_valid = 1'b1;
        bus.pal_wr_addr  = 4'd7;
        bus.pal_wr_data  = 24'h000000;
        bus.pix_valid    = 1'b1;
        bus.pattern      = 2'd1;
        bus.color_idx    = 2'd3;
        tick();
        bus.pal_wr_valid = 1'b0;
        bus.pix_valid    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pal_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b want 1", bus.pal_wr_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid got %b want 0", bus.out_valid);
        end
        rst = 1'b0;
        bus.vblank = 1'b1;
        tick();
        tick();
        bus.vblank = 1'b0;
        lookup(2'd1, 2'd3, 1'b0, rgb, ov);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL midrst_addr7 got %h want ffffff", rgb);
        end
        lookup(2'd1, 2'd1, 1'b0, rgb, ov);
        checks++;
        if (rgb !== 24'h555555) begin
            errors++;
            $display("FAIL midrst_addr5 got %h want 555555", rgb);
        end
`ifdef PALETTE_READBACK_EN
        bus.rd_addr = 4'd7;
        tick();
        checks++;
        if (bus.rd_data !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL readback7 got %h want ffffff", bus.rd_data);
        end
`endif
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.pix_valid    = 1'b0;
        bus.blank        = 1'b0;
        bus.vblank       = 1'b0;
        bus.pattern      = '0;
        bus.color_idx    = '0;
        bus.pal_wr_valid = 1'b0;
        bus.pal_wr_addr  = '0;
        bus.pal_wr_data  = '0;
`ifdef PALETTE_READBACK_EN
        bus.rd_addr      = '0;
`endif
        test_reset();
        test_sweep();
        test_blank();
        test_deferred_write();
        test_collision();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
